// File: rtl/bcd_timer_pkg.sv
// Shared types and helpers for the mixed-radix BCD timer.
package bcd_timer_pkg;

   localparam int unsigned BCD_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Limit a preset digit to the largest value its position may hold.
   function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] digit,
                                                  input logic [BCD_W-1:0] max);
      return (digit > max) ? max : digit;
   endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// One BCD digit of the up/down chain: next value, carry/borrow out, terminal flag.
module bcd_digit_step
   import bcd_timer_pkg::*;
(
   input  logic [BCD_W-1:0] digit_i,
   input  logic [BCD_W-1:0] max_i,
   input  logic             up_i,
   input  logic             en_i,
   output logic [BCD_W-1:0] digit_c_o,
   output logic             carry_c_o,
   output logic             term_c_o
);

   always_comb begin
      digit_c_o = digit_i;
      carry_c_o = 1'b0;
      term_c_o  = up_i ? (digit_i >= max_i) : (digit_i == '0);
      if (en_i) begin
         if (term_c_o) begin
            digit_c_o = up_i ? '0 : max_i;
            carry_c_o = 1'b1;
         end else if (up_i) begin
            digit_c_o = digit_i + BCD_W'(1);
         end else begin
            digit_c_o = digit_i - BCD_W'(1);
         end
      end
   end

endmodule

// File: rtl/bcd_timer.sv
// N-digit mixed-radix BCD up/down timer with run/pause, preset load, lap hold
// and terminal-count detection (wrap or saturate).
module bcd_timer
   import bcd_timer_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 4,
   parameter logic [31:0] DIGIT_MAX  = 32'h0000_9599,
   parameter bit          WRAP       = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        tick,
   input  logic                        start_stop,
   input  logic                        clear,
   input  logic                        up,
   input  logic                        load,
   input  logic [BCD_W*NUM_DIGITS-1:0] load_val,
   input  logic                        lap,
   output logic [BCD_W*NUM_DIGITS-1:0] count,
   output logic [BCD_W*NUM_DIGITS-1:0] disp,
   output logic                        lapped,
   output logic                        running,
   output logic                        tc
);

   localparam int unsigned CW = BCD_W * NUM_DIGITS;

   state_t          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic [CW-1:0]   snap_q, snap_d;
   logic            lapped_q, lapped_d;
   logic            tc_q, tc_d;

   logic [CW-1:0]         stepped_c;
   logic [CW-1:0]         clamped_c;
   logic [NUM_DIGITS-1:0] chain_c;
   logic [NUM_DIGITS-1:0] term_vec_c;
   logic                  top_carry_c;
   logic                  step_en_c;
   logic                  term_step_c;

   // A step only happens in RUN on a tick that clear/load do not pre-empt.
   assign step_en_c = tick && (state_q == RUN) && !clear && !load;
   assign chain_c[0] = step_en_c;

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      logic carry_c;

      bcd_digit_step u_step (
         .digit_i   (count_q[i*BCD_W +: BCD_W]),
         .max_i     (DIGIT_MAX[i*BCD_W +: BCD_W]),
         .up_i      (up),
         .en_i      (chain_c[i]),
         .digit_c_o (stepped_c[i*BCD_W +: BCD_W]),
         .carry_c_o (carry_c),
         .term_c_o  (term_vec_c[i])
      );

      if (i < NUM_DIGITS - 1) begin : g_mid
         assign chain_c[i+1] = carry_c;
      end else begin : g_top
         assign top_carry_c = carry_c;
      end

      assign clamped_c[i*BCD_W +: BCD_W] =
         bcd_clamp(load_val[i*BCD_W +: BCD_W], DIGIT_MAX[i*BCD_W +: BCD_W]);
   end

   // Carry leaving the top digit only occurs on an enabled step with every digit terminal.
   assign term_step_c = top_carry_c && (&term_vec_c);

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      snap_d   = snap_q;
      lapped_d = lapped_q;
      tc_d     = 1'b0;

      if (clear) begin
         state_d  = IDLE;
         count_d  = '0;
         snap_d   = '0;
         lapped_d = 1'b0;
      end else begin
         if (load) begin
            count_d = clamped_c;
         end else if (step_en_c) begin
            tc_d = term_step_c;
            if (!(term_step_c && !WRAP)) begin
               count_d = stepped_c;
            end
         end

         unique case (state_q)
            IDLE:    if (start_stop) state_d = RUN;
            RUN: begin
               if (term_step_c && !WRAP) state_d = DONE;
               else if (start_stop)      state_d = PAUSE;
            end
            PAUSE:   if (start_stop) state_d = RUN;
            DONE:    if (load)       state_d = PAUSE;
            default: state_d = IDLE;
         endcase

         // Snapshot takes the value from before this edge's step.
         if (lap && (state_q != IDLE)) begin
            if (lapped_q) begin
               lapped_d = 1'b0;
            end else begin
               snap_d   = count_q;
               lapped_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         count_q  <= '0;
         snap_q   <= '0;
         lapped_q <= 1'b0;
         tc_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         snap_q   <= snap_d;
         lapped_q <= lapped_d;
         tc_q     <= tc_d;
      end
   end

   assign count   = count_q;
   assign disp    = lapped_q ? snap_q : count_q;
   assign lapped  = lapped_q;
   assign running = (state_q == RUN);
   assign tc      = tc_q;

endmodule
